// File: rtl/pc_fetch_pkg.sv
// Shared CPU definitions: next-PC operation encodings, fetch FSM state
// encoding and the reset fetch address.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_op_e;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_DELIVER  = 2'd2;
    localparam logic [1:0] ST_WAIT_NPC = 2'd3;

    // Word address of byte address 0x0000_3000.
    localparam logic [29:0] PF_RESET_PC = 30'h0000_0C00;

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds the PC, reads one word from instruction
// memory, offers it to decode, then waits for the next PC.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [29:0] RESET_PC = PF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] npc,
    input  logic        npc_valid,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir_data,
    output logic [29:0] pc_out,
    output logic [31:0] fetch_cnt
);

    logic [1:0]  state_q, state_d;
    logic [29:0] pc_q,    pc_d;
    logic [31:0] ir_q,    ir_d;
    logic [31:0] cnt_q,   cnt_d;

    // Inputs are only honoured in the state that owns them; everything
    // else holds, which keeps ir_data/pc_out stable while decode stalls.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (ir_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = ST_WAIT_NPC;
                end
            end
            ST_WAIT_NPC: begin
                if (npc_valid) begin
                    pc_d    = npc;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign ir_valid  = (state_q == ST_DELIVER);
    assign ir_data   = ir_q;
    assign pc_out    = pc_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios followed by a randomized run
// against a behavioural fetch model.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] npc;
    logic        npc_valid;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [29:0] pc_out;
    logic [31:0] fetch_cnt;

    int n_chk = 0;
    int n_err = 0;

    pc_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .npc       (npc),
        .npc_valid (npc_valid),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir_data   (ir_data),
        .pc_out    (pc_out),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Behavioural model: what the fetch unit is currently doing.
    typedef enum int {M_START, M_FETCH, M_OFFER, M_NEXT} mphase_e;
    mphase_e     m_ph;
    logic [29:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_cnt;

    task automatic model_step();
        if (rst) begin
            m_ph = M_START; m_pc = 30'hC00; m_ir = '0; m_cnt = '0;
        end else if (m_ph == M_START) begin
            m_ph = M_FETCH;
        end else if (m_ph == M_FETCH && imem_ack) begin
            m_ir = imem_rdata; m_ph = M_OFFER;
        end else if (m_ph == M_OFFER && ir_ready) begin
            m_cnt = m_cnt + 1; m_ph = M_NEXT;
        end else if (m_ph == M_NEXT && npc_valid) begin
            m_pc = npc; m_ph = M_FETCH;
        end
    endtask

    task automatic model_check();
        chk("rnd_req",   {31'd0, imem_req}, {31'd0, m_ph == M_FETCH});
        chk("rnd_valid", {31'd0, ir_valid}, {31'd0, m_ph == M_OFFER});
        chk("rnd_addr",  {2'd0, imem_addr}, {2'd0, m_pc});
        chk("rnd_pc",    {2'd0, pc_out},    {2'd0, m_pc});
        chk("rnd_ir",    ir_data,           m_ir);
        chk("rnd_cnt",   fetch_cnt,         m_cnt);
    endtask

    initial begin
        rst = 1'b1; npc = '0; npc_valid = 1'b0; imem_ack = 1'b0;
        imem_rdata = '0; ir_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_pc",    {2'd0, pc_out},    32'h0000_0C00);
        chk("rst_ir",    ir_data,           32'd0);
        chk("rst_cnt",   fetch_cnt,         32'd0);

        // First fetch with 3 wait cycles
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("req_addr", {2'd0, imem_addr}, 32'h0000_0C00);
            cyc();
        end
        chk("req_last", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
        cyc();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        chk("dlv_valid", {31'd0, ir_valid}, 32'd1);
        chk("dlv_req",   {31'd0, imem_req}, 32'd0);
        chk("dlv_ir",    ir_data,           32'h2408_0005);

        // Decode stall, stray ack and an early npc pulse must all be ignored
        for (int i = 0; i < 4; i++) begin
            imem_ack  = (i == 1);
            npc_valid = (i == 2);
            npc       = 30'hC05;
            cyc();
            chk("stall_valid", {31'd0, ir_valid}, 32'd1);
            chk("stall_ir",    ir_data,           32'h2408_0005);
            chk("stall_pc",    {2'd0, pc_out},    32'h0000_0C00);
            chk("stall_cnt",   fetch_cnt,         32'd0);
        end
        imem_ack = 1'b0; npc_valid = 1'b0;
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
        chk("hs_cnt",   fetch_cnt,         32'd1);
        chk("hs_valid", {31'd0, ir_valid}, 32'd0);
        chk("hs_pc",    {2'd0, pc_out},    32'h0000_0C00);

        // Next PC accepted only while waiting for it
        npc_valid = 1'b1; npc = 30'hC01;
        cyc();
        npc_valid = 1'b0;
        chk("npc_pc",   {2'd0, pc_out},    32'h0000_0C01);
        chk("npc_req",  {31'd0, imem_req}, 32'd1);
        chk("npc_addr", {2'd0, imem_addr}, 32'h0000_0C01);

        // Zero-wait fetch, then counter wrap
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        imem_ack = 1'b0;
        chk("wrap_ir", ir_data, 32'h1234_5678);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
        chk("wrap_cnt", fetch_cnt, 32'd0);

        // Reset beats a simultaneous ack in REQ
        npc_valid = 1'b1; npc = 30'hC10;
        cyc();
        npc_valid = 1'b0;
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; rst = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("mid_state", {30'd0, dut.state_q}, 32'd0);
        chk("mid_pc",    {2'd0, pc_out},       32'h0000_0C00);
        chk("mid_valid", {31'd0, ir_valid},    32'd0);
        chk("mid_ir",    ir_data,              32'd0);

        // Throughput: one instruction every 3 cycles
        imem_ack = 1'b1; ir_ready = 1'b1; npc_valid = 1'b1;
        imem_rdata = 32'h0000_0001; npc = 30'hC00;
        rst = 1'b0;
        repeat (29) cyc();
        chk("tp_cnt29", fetch_cnt, 32'd9);
        cyc();
        chk("tp_cnt30", fetch_cnt, 32'd10);

        // Randomized run against the model
        imem_ack = 1'b0; ir_ready = 1'b0; npc_valid = 1'b0;
        rst = 1'b1;
        model_step();
        cyc();
        for (int i = 0; i < 600; i++) begin
            model_check();
            rst        = ($urandom_range(0, 49) == 0);
            imem_ack   = $urandom_range(0, 2) == 0;
            ir_ready   = $urandom_range(0, 1) == 0;
            npc_valid  = $urandom_range(0, 2) == 0;
            imem_rdata = $urandom;
            npc        = 30'($urandom);
            model_step();
            cyc();
        end
        model_check();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
